cpu_program_loader: RTL and testbench

Upstream loader for the 32×8 accumulator-CPU memory. It receives a program image as a valid/ready byte stream and writes it into the CPU RAM through a write port. It verifies an 8-bit checksum and releases the CPU from reset only after a clean load. It replaces the static memory-file image with a runtime-loadable one, and it holds the CPU in reset on any load failure.

---
 rtl/cpu_loader_pkg.sv | 31 +++
 rtl/loader_timeout_counter.sv | 37 +++
 rtl/cpu_program_loader.sv | 132 +++++++++++++
 tb/tb_cpu_program_loader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_loader_pkg
//  Description : Shared types and default sizing for the CPU program loader
//                and the accumulator-CPU RAM it fills.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_loader_pkg;

    // Default RAM geometry, shared with the CPU RAM sizing
    localparam int unsigned c_DEFAULT_MEM_DEPTH = 32;
    localparam int unsigned c_DEFAULT_DATA_W    = 8;

    // Loader control states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_CHECK = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    // Load failure reasons reported on err_code
    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_CSUM    = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_t;

endpackage
`default_nettype wire

// File: rtl/loader_timeout_counter.sv
`default_nettype none
// ============================================================================
//  Module      : loader_timeout_counter
//  Description : Idle-cycle counter for the loader. Counts enabled cycles
//                and flags expiry once the count sits at TIMEOUT_CYCLES-1;
//                the owner reacts to expiry on the next idle cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module loader_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // One spare bit so TIMEOUT_CYCLES-1 always fits, even for powers of two
    localparam int unsigned             c_CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [c_CNT_W-1:0]      c_LIMIT = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_count;

    // Count idle cycles; saturate at the limit so expiry stays asserted
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

    assign expired = (r_count == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/cpu_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_program_loader
//  Description : Receives a program image over a valid/ready byte stream,
//                writes it into the CPU RAM, verifies an 8-bit checksum and
//                releases the CPU from reset only after a clean load.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_program_loader
    import cpu_loader_pkg::*;
#(
    parameter int unsigned MEM_DEPTH      = c_DEFAULT_MEM_DEPTH,
    parameter int unsigned DATA_W         = c_DEFAULT_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_req,
    input  logic [DATA_W-1:0]            s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic                         mem_we,
    output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    output logic                         cpu_reset,
    output logic                         busy,
    output logic                         done,
    output logic [1:0]                   err_code
);

    localparam int unsigned          c_ADDR_W   = $clog2(MEM_DEPTH);
    // Byte index of the trailing checksum byte
    localparam logic [c_ADDR_W:0]    c_CSUM_IDX = (c_ADDR_W + 1)'(MEM_DEPTH);

    state_t              r_state;
    logic [c_ADDR_W:0]   r_byte_cnt;
    logic [DATA_W-1:0]   r_csum;

    logic                w_accept;
    logic [DATA_W-1:0]   w_csum_next;
    logic                w_to_clear;
    logic                w_to_enable;
    logic                w_expired;

    // s_ready is only ever high in RECV, so this is the stream handshake
    assign w_accept    = s_valid && s_ready;
    assign w_csum_next = r_csum + s_data;

    // Idle counting happens only in RECV; any accept or leaving RECV restarts it
    assign w_to_clear  = w_accept || (r_state != ST_RECV);
    assign w_to_enable = (r_state == ST_RECV) && !w_accept;

    loader_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_to_clear),
        .enable  (w_to_enable),
        .expired (w_expired)
    );

    // Load control FSM with registered write port and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_byte_cnt <= '0;
            r_csum     <= '0;
            s_ready    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_reset  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            mem_we <= 1'b0;
            case (r_state)
                ST_IDLE, ST_RUN, ST_ERROR: begin
                    if (load_req) begin
                        r_state    <= ST_RECV;
                        r_byte_cnt <= '0;
                        r_csum     <= '0;
                        done       <= 1'b0;
                        err_code   <= ERR_NONE;
                        cpu_reset  <= 1'b1;
                        s_ready    <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ST_RECV: begin
                    if (w_accept) begin
                        r_csum <= w_csum_next;
                        if (r_byte_cnt == c_CSUM_IDX) begin
                            // Checksum byte: folded into the sum, never written
                            r_state <= ST_CHECK;
                            s_ready <= 1'b0;
                        end else begin
                            mem_we     <= 1'b1;
                            mem_addr   <= r_byte_cnt[c_ADDR_W-1:0];
                            mem_wdata  <= s_data;
                            r_byte_cnt <= r_byte_cnt + (c_ADDR_W + 1)'(1);
                        end
                    end else if (w_expired) begin
                        // RAM keeps whatever was written so far
                        r_state  <= ST_ERROR;
                        err_code <= ERR_TIMEOUT;
                        s_ready  <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    busy <= 1'b0;
                    if (r_csum == '0) begin
                        r_state   <= ST_RUN;
                        done      <= 1'b1;
                        cpu_reset <= 1'b0;
                    end else begin
                        r_state  <= ST_ERROR;
                        err_code <= ERR_CSUM;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_program_loader
//  Description : Directed self-checking bench for cpu_program_loader with a
//                write scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_program_loader;

    localparam int c_TIMEOUT = 1024;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_req;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       mem_we;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_reset;
    logic       busy;
    logic       done;
    logic [1:0] err_code;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n_writes = 0;

    // Expected RAM writes as {addr, data}
    logic [12:0] exp_q[$];

    cpu_program_loader #(
        .MEM_DEPTH      (32),
        .DATA_W         (8),
        .TIMEOUT_CYCLES (c_TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load_req  (load_req),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    // Rising-edge count, used to measure load latency
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the next expected write
    always @(negedge clk) begin
        logic [12:0] e;
        if (mem_we === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {19'b0, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("write", {19'b0, mem_addr, mem_wdata}, {19'b0, e});
            end
        end
    end

    // Present one byte and hold it until accepted (bounded)
    task automatic send(input logic [7:0] d, input bit push, input int idx);
        int guard = 0;
        bit acc   = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        if (push) exp_q.push_back({idx[4:0], d});
        while (!acc && guard < 50) begin
            acc = (s_ready === 1'b1);
            @(negedge clk);
            guard++;
        end
        check("send_accept", 32'(acc), 32'd1);
        s_valid = 1'b0;
    endtask

    // Image bytes 0..31 (data = address) followed by a checksum byte
    task automatic load_image(input logic [7:0] csum, input int gap_max, input int req_idx);
        for (int i = 0; i < 32; i++) begin
            int gaps;
            gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (gaps) @(negedge clk);
            load_req = (i == req_idx);
            send(8'(i), 1'b1, i);
            load_req = 1'b0;
        end
        send(csum, 1'b0, 0);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_s_ready"},   32'(s_ready),   32'd0);
        check({pfx, "_mem_we"},    32'(mem_we),    32'd0);
        check({pfx, "_mem_addr"},  32'(mem_addr),  32'd0);
        check({pfx, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        check({pfx, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        check({pfx, "_busy"},      32'(busy),      32'd0);
        check({pfx, "_done"},      32'(done),      32'd0);
        check({pfx, "_err_code"},  32'(err_code),  32'd0);
    endtask

    task automatic start_load(output int t_req);
        @(negedge clk);
        t_req    = cyc;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    initial begin
        int t0;
        int w0;
        reset    = 1'b1;
        load_req = 1'b0;
        s_valid  = 1'b0;
        s_data   = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;
        @(negedge clk);
        check("idle_s_ready", 32'(s_ready), 32'd0);
        check("idle_cpu_reset", 32'(cpu_reset), 32'd1);

        // Good load from IDLE, back-to-back bytes
        w0 = n_writes;
        start_load(t0);
        check("s1_s_ready", 32'(s_ready), 32'd1);
        check("s1_busy", 32'(busy), 32'd1);
        load_image(8'h10, 0, -1);
        check("s1_check_cpu_reset", 32'(cpu_reset), 32'd1);
        check("s1_check_s_ready", 32'(s_ready), 32'd0);
        @(negedge clk);
        check("s1_done", 32'(done), 32'd1);
        check("s1_cpu_reset", 32'(cpu_reset), 32'd0);
        check("s1_err", 32'(err_code), 32'd0);
        check("s1_busy_end", 32'(busy), 32'd0);
        check("s1_latency", 32'(cyc - t0), 32'd35);
        check("s1_writes", 32'(n_writes - w0), 32'd32);

        // Reload from RUN with a bad checksum; load_req mid-stream is ignored
        w0 = n_writes;
        start_load(t0);
        check("s2_cpu_reset_rise", 32'(cpu_reset), 32'd1);
        check("s2_done_clr", 32'(done), 32'd0);
        check("s2_s_ready", 32'(s_ready), 32'd1);
        load_image(8'h11, 0, 10);
        @(negedge clk);
        check("s2_err", 32'(err_code), 32'd1);
        check("s2_done", 32'(done), 32'd0);
        check("s2_cpu_reset", 32'(cpu_reset), 32'd1);
        check("s2_writes", 32'(n_writes - w0), 32'd32);
        repeat (4) @(negedge clk);
        check("s2_err_held", 32'(err_code), 32'd1);
        check("s2_cpu_held", 32'(cpu_reset), 32'd1);

        // Good load from ERROR with random s_valid gaps
        w0 = n_writes;
        start_load(t0);
        check("s3_err_clr", 32'(err_code), 32'd0);
        load_image(8'h10, 3, -1);
        @(negedge clk);
        check("s3_done", 32'(done), 32'd1);
        check("s3_cpu_reset", 32'(cpu_reset), 32'd0);
        check("s3_err", 32'(err_code), 32'd0);
        check("s3_writes", 32'(n_writes - w0), 32'd32);

        // Stall after byte 5 until the inter-byte timeout fires
        w0 = n_writes;
        start_load(t0);
        for (int i = 0; i < 6; i++) send(8'(i), 1'b1, i);
        repeat (c_TIMEOUT - 1) @(negedge clk);
        check("s4_pre_err", 32'(err_code), 32'd0);
        check("s4_pre_s_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        check("s4_err", 32'(err_code), 32'd2);
        check("s4_s_ready", 32'(s_ready), 32'd0);
        check("s4_cpu_reset", 32'(cpu_reset), 32'd1);
        check("s4_done", 32'(done), 32'd0);
        check("s4_busy", 32'(busy), 32'd0);
        check("s4_writes", 32'(n_writes - w0), 32'd6);

        // Reset asserted while byte 12 is on the stream
        w0 = n_writes;
        start_load(t0);
        for (int i = 0; i < 12; i++) send(8'(i), 1'b1, i);
        s_valid = 1'b1;
        s_data  = 8'd12;
        reset   = 1'b1;
        @(negedge clk);
        check_reset_outputs("s5");
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("s5_s_ready", 32'(s_ready), 32'd0);
        check("s5_cpu_reset", 32'(cpu_reset), 32'd1);
        check("s5_writes", 32'(n_writes - w0), 32'd12);
        s_valid = 1'b0;

        @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute bound on run time
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
